// File: rtl/disp7seg_mux.sv
// ---------------------------------------------------------------------------
// disp7seg_mux
//
// Time-multiplexed driver for an NDIG-digit seven-segment display. A free
// running prescaler, advanced only while en=1, produces a scan tick every
// 2^DIVW enabled cycles. On each tick the digit index advances and the
// segment pattern and one-hot anode select for the new digit are registered.
// Display data is captured into shadow registers on load and only reaches
// the segments at a tick, so a digit never changes while it is lit.
//
// Parameters
//   NDIG        number of digits (2..8)
//   DIVW        prescaler width; scan tick every 2^DIVW enabled cycles
//   HEX         0: codes 10..15 show "-"; 1: codes 10..15 show A,b,C,d,E,F
//   ACTIVE_LOW  1: seg and an are inverted at the output
//
// Ports
//   clk       clock, rising edge
//   reset     synchronous, active-high
//   en        scan enable; when low the display is dark and the scan holds
//   load      capture din/dp_in into the shadow registers on this edge
//   din       digit codes, digit i = din[4i+3:4i], digit 0 least significant
//   dp_in     decimal point per digit
//   blank_lz  leading-zero blanking enable
//   seg       {dp,g,f,e,d,c,b,a}, registered
//   an        one-hot digit select, registered
//   frame     one-cycle pulse after the scan wraps to digit 0, registered
// ---------------------------------------------------------------------------
module disp7seg_mux #(
    parameter int NDIG       = 4,
    parameter int DIVW       = 16,
    parameter bit HEX        = 1'b0,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              load,
    input  logic [4*NDIG-1:0] din,
    input  logic [NDIG-1:0]   dp_in,
    input  logic              blank_lz,
    output logic [7:0]        seg,
    output logic [NDIG-1:0]   an,
    output logic              frame
);

    localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

    // Output levels meaning "segments off" and "no digit selected".
    localparam logic [7:0]      SEG_OFF = {8{ACTIVE_LOW}};
    localparam logic [NDIG-1:0] AN_OFF  = {NDIG{ACTIVE_LOW}};

    logic [DIVW-1:0]   presc_q;
    logic [IW-1:0]     idx_q;
    logic [4*NDIG-1:0] din_q;
    logic [NDIG-1:0]   dp_q;
    logic [7:0]        seg_q;
    logic [NDIG-1:0]   an_q;
    logic              frame_q;

    logic              tick;
    logic [IW-1:0]     idx_nxt;
    logic [3:0]        code_nxt;
    logic [NDIG-1:0]   lead_zero;
    logic              blank_nxt;
    logic [7:0]        seg_d;
    logic [NDIG-1:0]   an_d;

    // Segment pattern {g,f,e,d,c,b,a} for one digit code, active-high.
    function automatic logic [6:0] glyph(input logic [3:0] code);
        logic [6:0] g;
        g = 7'h40;
        case (code)
            4'd0:  g = 7'h3F;
            4'd1:  g = 7'h06;
            4'd2:  g = 7'h5B;
            4'd3:  g = 7'h4F;
            4'd4:  g = 7'h66;
            4'd5:  g = 7'h6D;
            4'd6:  g = 7'h7D;
            4'd7:  g = 7'h07;
            4'd8:  g = 7'h7F;
            4'd9:  g = 7'h67;
            4'd10: g = HEX ? 7'h77 : 7'h40;
            4'd11: g = HEX ? 7'h7C : 7'h40;
            4'd12: g = HEX ? 7'h39 : 7'h40;
            4'd13: g = HEX ? 7'h5E : 7'h40;
            4'd14: g = HEX ? 7'h79 : 7'h40;
            default: g = HEX ? 7'h71 : 7'h40;
        endcase
        return g;
    endfunction

    // NOTE: every variable assigned here gets a value on every path first,
    // otherwise synthesis infers a latch to hold the old value.
    always_comb begin
        tick    = en && (presc_q == '1);
        idx_nxt = (idx_q == IW'(NDIG - 1)) ? '0 : idx_q + 1'b1;

        // lead_zero[i] is set when digit i and every digit above it are 0.
        lead_zero[NDIG-1] = (din_q[4*(NDIG-1) +: 4] == 4'd0);
        for (int i = NDIG - 2; i >= 0; i--) begin
            lead_zero[i] = lead_zero[i+1] && (din_q[4*i +: 4] == 4'd0);
        end

        // The shadow registers are read here, so a load on the tick edge
        // cannot reach the digit being lit on that same edge.
        code_nxt  = din_q[{idx_nxt, 2'b00} +: 4];
        blank_nxt = blank_lz && (idx_nxt != '0) && lead_zero[idx_nxt];
        seg_d     = {dp_q[idx_nxt], blank_nxt ? 7'h00 : glyph(code_nxt)} ^ SEG_OFF;
        an_d      = (NDIG'(1) << idx_nxt) ^ AN_OFF;
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the shadow data is reset too, so the first frame after
            // reset shows zeros rather than whatever was left behind.
            presc_q <= '0;
            idx_q   <= '0;
            din_q   <= '0;
            dp_q    <= '0;
            seg_q   <= SEG_OFF;
            an_q    <= AN_OFF;
            frame_q <= 1'b0;
        end else begin
            if (load) begin
                din_q <= din;
                dp_q  <= dp_in;
            end

            frame_q <= 1'b0;
            if (!en) begin
                // Dark display; prescaler and index hold so the scan
                // resumes where it stopped.
                seg_q <= SEG_OFF;
                an_q  <= AN_OFF;
            end else begin
                presc_q <= presc_q + 1'b1;
                if (tick) begin
                    idx_q   <= idx_nxt;
                    seg_q   <= seg_d;
                    an_q    <= an_d;
                    frame_q <= (idx_nxt == '0);
                end
            end
        end
    end

    assign seg   = seg_q;
    assign an    = an_q;
    assign frame = frame_q;

endmodule

// File: tb/tb_disp7seg_mux.sv
// ---------------------------------------------------------------------------
// tb_disp7seg_mux
//
// Two instances share all inputs: u_dec (HEX=0, active-high outputs) and
// u_hex (HEX=1, active-low outputs), both NDIG=4, DIVW=2. A reference model
// built from the display rules (count enabled cycles, pick digit by integer
// division, look the glyph up in a table) predicts every output each cycle.
// Directed steps cover the scan order, hex/dash codes, blanking, load on a
// tick, en drop-out and reset, then a randomized run follows.
// ---------------------------------------------------------------------------
module tb_disp7seg_mux;

    localparam int NDIG = 4;
    localparam int DIVW = 2;
    localparam int PER  = 1 << DIVW;

    logic        clk = 1'b0;
    logic        reset, en, load, blank_lz;
    logic [15:0] din;
    logic [3:0]  dp_in;
    logic [7:0]  seg_dec, seg_hex;
    logic [3:0]  an_dec, an_hex;
    logic        frame_dec, frame_hex;

    always #5 clk = ~clk;

    disp7seg_mux #(.NDIG(NDIG), .DIVW(DIVW), .HEX(1'b0), .ACTIVE_LOW(1'b0)) u_dec (
        .clk(clk), .reset(reset), .en(en), .load(load), .din(din),
        .dp_in(dp_in), .blank_lz(blank_lz),
        .seg(seg_dec), .an(an_dec), .frame(frame_dec)
    );

    disp7seg_mux #(.NDIG(NDIG), .DIVW(DIVW), .HEX(1'b1), .ACTIVE_LOW(1'b1)) u_hex (
        .clk(clk), .reset(reset), .en(en), .load(load), .din(din),
        .dp_in(dp_in), .blank_lz(blank_lz),
        .seg(seg_hex), .an(an_hex), .frame(frame_hex)
    );

    // Glyph tables indexed by digit code.
    logic [6:0] dec_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h67, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
    logic [6:0] hex_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h67, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Reference model state (true polarity).
    int         m_cnt   = 0;   // enabled cycles since last tick
    int         m_idx   = 0;
    int         m_value = 0;   // latched display value as an integer
    logic [3:0] m_dp    = '0;
    logic [7:0] m_seg_dec = '0, m_seg_hex = '0;
    logic [3:0] m_an    = '0;
    logic       m_frame = 1'b0;

    int n_pass  = 0;
    int n_total = 0;

    function automatic logic [7:0] model_glyph(input int value, input logic [3:0] dps,
                                               input int pos, input bit hex, input bit blank_en);
        int   upper;
        int   code;
        bit   blanked;
        upper   = value / (16 ** pos);
        code    = upper % 16;
        blanked = blank_en && (pos > 0) && (upper == 0);
        return {dps[pos], blanked ? 7'h00 : (hex ? hex_tbl[code] : dec_tbl[code])};
    endfunction

    // Advance the model by one clock edge using the inputs applied at it.
    task automatic model_step();
        int         old_value;
        logic [3:0] old_dp;
        if (reset) begin
            m_cnt = 0; m_idx = 0; m_value = 0; m_dp = '0;
            m_seg_dec = '0; m_seg_hex = '0; m_an = '0; m_frame = 1'b0;
        end else begin
            old_value = m_value;
            old_dp    = m_dp;
            if (load) begin
                m_value = int'(din);
                m_dp    = dp_in;
            end
            m_frame = 1'b0;
            if (!en) begin
                m_seg_dec = '0; m_seg_hex = '0; m_an = '0;
            end else begin
                m_cnt = m_cnt + 1;
                if (m_cnt == PER) begin
                    m_cnt     = 0;
                    m_idx     = (m_idx + 1) % NDIG;
                    m_seg_dec = model_glyph(old_value, old_dp, m_idx, 1'b0, blank_lz);
                    m_seg_hex = model_glyph(old_value, old_dp, m_idx, 1'b1, blank_lz);
                    m_an      = 4'(1 << m_idx);
                    m_frame   = (m_idx == 0);
                end
            end
        end
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // One clock edge, model update, then compare all outputs of both DUTs.
    task automatic cycle();
        logic [7:0] exp_seg_hex;
        logic [3:0] exp_an_hex;
        @(posedge clk);
        model_step();
        #1;
        exp_seg_hex = ~m_seg_hex;
        exp_an_hex  = ~m_an;
        check("seg_dec",   16'(seg_dec),   16'(m_seg_dec));
        check("an_dec",    16'(an_dec),    16'(m_an));
        check("frame_dec", 16'(frame_dec), 16'(m_frame));
        check("seg_hex",   16'(seg_hex),   16'(exp_seg_hex));
        check("an_hex",    16'(an_hex),    16'(exp_an_hex));
        check("frame_hex", 16'(frame_hex), 16'(m_frame));
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    // Reset, then release with a load on the first enabled edge.
    task automatic sync_load(input logic [15:0] d, input logic [3:0] dps, input logic blk);
        reset = 1'b1; en = 1'b1; load = 1'b0;
        cycle();
        reset = 1'b0; load = 1'b1; din = d; dp_in = dps; blank_lz = blk;
        cycle();
        load = 1'b0;
    endtask

    logic [7:0] scan_seg [4] = '{8'h4F, 8'h5B, 8'h06, 8'h66};
    logic [3:0] scan_an  [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};

    initial begin
        reset = 1'b1; en = 1'b0; load = 1'b0; din = '0; dp_in = '0; blank_lz = 1'b0;

        // Reset state.
        run(2);
        check("rst_seg_dec", 16'(seg_dec), 16'h00);
        check("rst_an_dec",  16'(an_dec),  16'h0);
        check("rst_seg_hex", 16'(seg_hex), 16'hFF);
        check("rst_an_hex",  16'(an_hex),  16'hF);

        // Scan of 0x1234: digits 1,2,3,0 each held PER cycles.
        sync_load(16'h1234, 4'b0000, 1'b0);
        for (int k = 0; k < 4; k++) begin
            run(k == 0 ? PER - 1 : PER);
            check("scan_seg", 16'(seg_dec), 16'(scan_seg[k]));
            check("scan_an",  16'(an_dec),  16'(scan_an[k]));
        end
        check("scan_frame", 16'(frame_dec), 16'h1);

        // Codes A and F: dash in decimal mode, letters in hex mode.
        sync_load(16'h00AF, 4'b0000, 1'b0);
        run(PER - 1);
        check("mode_d1_dec", 16'(seg_dec), 16'h40);
        check("mode_d1_hex", 16'(seg_hex), 16'h88);
        run(3 * PER);
        check("mode_d0_dec", 16'(seg_dec), 16'h40);
        check("mode_d0_hex", 16'(seg_hex), 16'h8E);

        // Leading-zero blanking with a dp on a blanked digit.
        sync_load(16'h0050, 4'b0100, 1'b1);
        run(PER - 1);
        check("blank_d1", 16'(seg_dec), 16'h6D);
        run(PER);
        check("blank_d2", 16'(seg_dec), 16'h80);
        run(PER);
        check("blank_d3", 16'(seg_dec), 16'h00);
        run(PER);
        check("blank_d0", 16'(seg_dec), 16'h3F);

        // Load on the tick edge: current digit keeps old data.
        sync_load(16'h1234, 4'b0000, 1'b0);
        run(PER - 2);
        load = 1'b1; din = 16'h5678;
        cycle();
        load = 1'b0;
        check("ldtick_old", 16'(seg_dec), 16'h4F);
        run(PER);
        check("ldtick_new", 16'(seg_dec), 16'h7D);

        // en dropped mid-digit for 5 cycles.
        run(1);
        en = 1'b0;
        cycle();
        check("endrop_an",  16'(an_dec),  16'h0);
        check("endrop_seg", 16'(seg_dec), 16'h00);
        check("endrop_anh", 16'(an_hex),  16'hF);
        run(4);
        en = 1'b1;
        run(2);
        check("resume_dark", 16'(an_dec), 16'h0);
        cycle();
        check("resume_an",  16'(an_dec),  16'b1000);
        check("resume_seg", 16'(seg_dec), 16'h6D);

        // Reset mid-scan, then first tick selects digit 1.
        run(2);
        reset = 1'b1;
        cycle();
        check("midrst_seg_hex",   16'(seg_hex),   16'hFF);
        check("midrst_an_hex",    16'(an_hex),    16'hF);
        check("midrst_frame_hex", 16'(frame_hex), 16'h0);
        reset = 1'b0; en = 1'b1;
        run(PER);
        check("first_tick_an",  16'(an_dec),  16'b0010);
        check("first_tick_seg", 16'(seg_dec), 16'h3F);

        // Randomized run against the model.
        for (int i = 0; i < 1500; i++) begin
            reset = ($urandom_range(0, 199) == 0);
            en    = ($urandom_range(0, 9) != 0);
            load  = ($urandom_range(0, 7) == 0);
            for (int n = 0; n < 4; n++) begin
                din[4*n +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            end
            dp_in = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 31) == 0) blank_lz = ~blank_lz;
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
